// File: rtl/lcd_bus_reader_if.sv
// Host and LCD pin bundle for the HD44780 read-side controller.
// LCD_DATA is a shared bus owned by the writer; the reader only samples it.
interface lcd_bus_reader_if;
  logic       iStart;
  logic       iRS;
  logic       iPoll;
  logic       oReady;
  logic       oDone;
  logic [7:0] oData;
  logic       oBusyFlag;
  logic [6:0] oAddr;
  logic       oTimeout;
  wire  [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  modport master (
    output iStart, iRS, iPoll,
    input  oReady, oDone, oData, oBusyFlag, oAddr, oTimeout,
    input  LCD_DATA, LCD_RW, LCD_EN, LCD_RS
  );

  modport slave (
    input  iStart, iRS, iPoll,
    output oReady, oDone, oData, oBusyFlag, oAddr, oTimeout,
    input  LCD_DATA,
    output LCD_RW, LCD_EN, LCD_RS
  );
endinterface

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle controller: busy-flag/address or data reads, with optional
// busy-flag polling until clear or until POLL_MAX reads have been made.
module lcd_bus_reader #(
  parameter int unsigned T_AS     = 4,
  parameter int unsigned T_EN     = 25,
  parameter int unsigned T_REC    = 50,
  parameter int unsigned POLL_MAX = 2000
) (
  input logic             iCLK,
  input logic             iRST_N,
  lcd_bus_reader_if.slave bus
);

  // All timing parameters must be at least 1; the counter holds T-1.
  localparam int unsigned TMax  = (T_AS > T_EN) ? ((T_AS > T_REC) ? T_AS : T_REC)
                                                : ((T_EN > T_REC) ? T_EN : T_REC);
  localparam int unsigned CntW  = $clog2(TMax + 1);
  localparam int unsigned PollW = ($clog2(POLL_MAX + 1) > 11) ? $clog2(POLL_MAX + 1) : 11;

  typedef enum logic [2:0] {StIdle, StSetup, StEnHi, StEnLo, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [PollW-1:0] poll_cnt_q;
  logic             rs_q;
  logic             poll_q;
  logic             ready_q;
  logic             done_q;
  logic [7:0]       data_q;
  logic             bf_q;
  logic [6:0]       addr_q;
  logic             timeout_q;
  logic             lcd_rw_q;
  logic             lcd_en_q;
  logic             lcd_rs_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      poll_cnt_q <= '0;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      data_q     <= 8'h00;
      bf_q       <= 1'b0;
      addr_q     <= 7'h00;
      timeout_q  <= 1'b0;
      lcd_rw_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.iStart) begin
            rs_q       <= bus.iRS;
            poll_q     <= bus.iPoll & ~bus.iRS;
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
            ready_q    <= 1'b0;
            lcd_rw_q   <= 1'b1;
            lcd_rs_q   <= bus.iRS;
            cnt_q      <= CntW'(T_AS - 1);
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            lcd_en_q <= 1'b1;
            cnt_q    <= CntW'(T_EN - 1);
            state_q  <= StEnHi;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StEnHi: begin
          if (cnt_q == '0) begin
            // Sample at the end of the enable window, when read data is settled.
            data_q <= bus.LCD_DATA;
            if (!rs_q) begin
              bf_q   <= bus.LCD_DATA[7];
              addr_q <= bus.LCD_DATA[6:0];
            end
            lcd_en_q   <= 1'b0;
            poll_cnt_q <= poll_cnt_q + PollW'(1);
            cnt_q      <= CntW'(T_REC - 1);
            state_q    <= StEnLo;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StEnLo: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (poll_q && bf_q && (poll_cnt_q < PollW'(POLL_MAX))) begin
            // RS/RW stay put across poll reads, so setup timing is already met.
            cnt_q   <= CntW'(T_AS - 1);
            state_q <= StSetup;
          end else begin
            timeout_q <= poll_q & bf_q;
            lcd_rw_q  <= 1'b0;
            lcd_rs_q  <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.oReady    = ready_q;
  assign bus.oDone     = done_q;
  assign bus.oData     = data_q;
  assign bus.oBusyFlag = bf_q;
  assign bus.oAddr     = addr_q;
  assign bus.oTimeout  = timeout_q;
  assign bus.LCD_RW    = lcd_rw_q;
  assign bus.LCD_EN    = lcd_en_q;
  assign bus.LCD_RS    = lcd_rs_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: single reads, polling, timeout, busy
// rejection and asynchronous reset, plus continuous bus-timing monitors.
module tb_lcd_bus_reader;

  localparam int unsigned TAs = 4;
  localparam int unsigned PollMax = 5;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;

  lcd_bus_reader_if bus ();

  lcd_bus_reader #(
    .T_AS    (TAs),
    .T_EN    (25),
    .T_REC   (50),
    .POLL_MAX(PollMax)
  ) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bus)
  );

  always #10 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Bus model: the first busy_reads pulses of an operation return 8'h80.
  logic [7:0] bus_val    = 8'h00;
  int         busy_reads = 0;
  int         pulse_base = 0;

  int pulses       = 0;
  int en_hi_cycles = 0;
  int rw_hi_cycles = 0;
  int rs_lo_rw     = 0;
  int done_cnt     = 0;
  int viol         = 0;

  assign bus.LCD_DATA = (busy_reads != 0 && (pulses - pulse_base) <= busy_reads) ? 8'h80
                                                                                 : bus_val;

  always @(posedge bus.LCD_EN) pulses++;

  logic prev_en = 1'b0, prev_rw = 1'b0, prev_rs = 1'b0;
  int   stable  = 100;
  always @(negedge iCLK) begin
    if (bus.LCD_EN) en_hi_cycles++;
    if (bus.LCD_RW) rw_hi_cycles++;
    if (bus.LCD_RW && !bus.LCD_RS) rs_lo_rw++;
    if (bus.oDone) done_cnt++;
    if (bus.LCD_RS != prev_rs || bus.LCD_RW != prev_rw) begin
      if (bus.LCD_EN && prev_en) viol++;
      stable = 1;
    end else begin
      stable++;
    end
    if (bus.LCD_EN && !prev_en && stable <= int'(TAs)) viol++;
    prev_en = bus.LCD_EN;
    prev_rw = bus.LCD_RW;
    prev_rs = bus.LCD_RS;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int b_pulse, b_en, b_rw, b_rslo, b_done;
  task automatic snap();
    b_pulse    = pulses;
    pulse_base = pulses;
    b_en       = en_hi_cycles;
    b_rw       = rw_hi_cycles;
    b_rslo     = rs_lo_rw;
    b_done     = done_cnt;
  endtask

  // Accept one operation, scramble iRS/iPoll afterwards, optionally poke iStart
  // once poke_at cycles after accept, and return cycles until oDone.
  task automatic run_op(input logic rs, input logic poll, input int poke_at,
                        output int lat);
    @(negedge iCLK);
    bus.iStart = 1'b1;
    bus.iRS    = rs;
    bus.iPoll  = poll;
    @(posedge iCLK);
    #1;
    bus.iStart = 1'b0;
    bus.iRS    = ~rs;
    bus.iPoll  = ~poll;
    lat = 0;
    while (lat < 5000) begin
      @(posedge iCLK);
      lat++;
      #1;
      bus.iStart = (lat == poke_at);
      if (bus.oDone) break;
    end
    bus.iStart = 1'b0;
    if (lat >= 5000) check_eq("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  int lat;

  initial begin
    bus.iStart = 1'b0;
    bus.iRS    = 1'b0;
    bus.iPoll  = 1'b0;
    idle(3);
    check_eq("rst_ready", bus.oReady, 1);
    check_eq("rst_done", bus.oDone, 0);
    check_eq("rst_en", bus.LCD_EN, 0);
    check_eq("rst_rw", bus.LCD_RW, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    idle(2);
    check_eq("rst_data", bus.oData, 8'h00);
    check_eq("rst_bf_addr", {bus.oBusyFlag, bus.oAddr}, 8'h00);
    check_eq("rst_timeout", bus.oTimeout, 0);
    check_eq("rst_rs", bus.LCD_RS, 0);

    // Single busy-flag/address read.
    bus_val = 8'h85;
    snap();
    run_op(1'b0, 1'b0, -1, lat);
    check_eq("bf_latency", lat, 80);
    check_eq("bf_data", bus.oData, 8'h85);
    check_eq("bf_flag", bus.oBusyFlag, 1);
    check_eq("bf_addr", bus.oAddr, 7'h05);
    check_eq("bf_timeout", bus.oTimeout, 0);
    check_eq("bf_ready", bus.oReady, 1);
    idle(5);
    check_eq("bf_en_cycles", en_hi_cycles - b_en, 25);
    check_eq("bf_rw_cycles", rw_hi_cycles - b_rw, 79);
    check_eq("bf_pulses", pulses - b_pulse, 1);
    check_eq("bf_done_cnt", done_cnt - b_done, 1);
    check_eq("bf_rw_idle", bus.LCD_RW, 0);

    // Data read leaves busy flag and address alone.
    bus_val = 8'h41;
    snap();
    run_op(1'b1, 1'b1, -1, lat);
    idle(3);
    check_eq("rd_latency", lat, 80);
    check_eq("rd_data", bus.oData, 8'h41);
    check_eq("rd_bf_addr", {bus.oBusyFlag, bus.oAddr}, 8'h85);
    check_eq("rd_rs_low", rs_lo_rw - b_rslo, 0);
    check_eq("rd_rw_cycles", rw_hi_cycles - b_rw, 79);
    check_eq("rd_timeout", bus.oTimeout, 0);

    // Poll: three busy reads, then ready with address 0x12.
    bus_val    = 8'h12;
    busy_reads = 3;
    snap();
    run_op(1'b0, 1'b1, -1, lat);
    idle(3);
    busy_reads = 0;
    check_eq("poll_latency", lat, 317);
    check_eq("poll_pulses", pulses - b_pulse, 4);
    check_eq("poll_bf_addr", {bus.oBusyFlag, bus.oAddr}, 8'h12);
    check_eq("poll_timeout", bus.oTimeout, 0);
    check_eq("poll_done_cnt", done_cnt - b_done, 1);

    // Timeout: busy forever, stops after PollMax reads.
    bus_val = 8'hFF;
    snap();
    run_op(1'b0, 1'b1, -1, lat);
    check_eq("to_timeout_at_done", bus.oTimeout, 1);
    idle(20);
    check_eq("to_latency", lat, 5 * 79 + 1);
    check_eq("to_pulses", pulses - b_pulse, PollMax);
    check_eq("to_flag", bus.oBusyFlag, 1);
    check_eq("to_timeout_hold", bus.oTimeout, 1);

    // iStart during EN_HI is dropped.
    bus_val = 8'h33;
    snap();
    run_op(1'b0, 1'b0, 10, lat);
    idle(100);
    check_eq("rej_latency", lat, 80);
    check_eq("rej_pulses", pulses - b_pulse, 1);
    check_eq("rej_done_cnt", done_cnt - b_done, 1);
    check_eq("rej_timeout_clr", bus.oTimeout, 0);
    check_eq("rej_addr", bus.oAddr, 7'h33);

    // iStart during the DONE cycle is dropped too.
    snap();
    run_op(1'b0, 1'b0, 79, lat);
    idle(100);
    check_eq("done_poke_pulses", pulses - b_pulse, 1);
    check_eq("done_poke_ready", bus.oReady, 1);

    // Asynchronous reset in the middle of EN_HI.
    bus_val = 8'h07;
    snap();
    @(negedge iCLK);
    bus.iStart = 1'b1;
    bus.iRS    = 1'b0;
    bus.iPoll  = 1'b0;
    @(posedge iCLK);
    #1;
    bus.iStart = 1'b0;
    idle(10);
    check_eq("ar_en_before", bus.LCD_EN, 1);
    #2;
    iRST_N = 1'b0;
    #1;
    check_eq("ar_en_async", bus.LCD_EN, 0);
    check_eq("ar_ready_async", bus.oReady, 1);
    check_eq("ar_rw_async", bus.LCD_RW, 0);
    idle(3);
    @(negedge iCLK);
    iRST_N = 1'b1;
    idle(100);
    check_eq("ar_no_done", done_cnt - b_done, 0);
    check_eq("ar_data_clr", bus.oData, 8'h00);
    run_op(1'b0, 1'b0, -1, lat);
    idle(3);
    check_eq("ar_next_latency", lat, 80);
    check_eq("ar_next_addr", bus.oAddr, 7'h07);
    check_eq("ar_done_cnt", done_cnt - b_done, 1);

    check_eq("bus_timing_viol", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
